cla_adder_pipe: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor; the next generation of the team's 4-bit CLA adder.
- Operand width and lookahead group size are parameters. One group is resolved per pipeline stage, with carry passed stage to stage.
- Adds valid/ready handshakes with backpressure, a subtract mode, and a signed-overflow flag.
- Used as the arithmetic datapath block in test benches and larger datapaths that need a registered, streaming adder.

---
 rtl/cla_defs.sv | 23 ++
 rtl/cla_group.sv | 56 +++++
 rtl/cla_adder_pipe.sv | 148 ++++++++++++++
 tb/tb_cla_adder_pipe.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cla_defs.sv
// Shared constants and helpers for the pipelined carry-lookahead adder:
// default sizes, the pipeline-depth derivation and the parameter sanity check.
package cla_defs;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_GROUP = 4;

    // One lookahead group is resolved per stage, so depth is WIDTH/GROUP.
    function automatic int nstage(input int width, input int group);
        if (group < 1) begin
            return 1;
        end
        return width / group;
    endfunction

    function automatic bit params_ok(input int width, input int group);
        if (group < 1 || width < group) begin
            return 1'b0;
        end
        return (width % group) == 0;
    endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead slice: every internal carry is a flat
// sum of generate/propagate products, with group P/G exported for tree use.
module cla_group
    import cla_defs::*;
#(
    parameter int GROUP = DEF_GROUP
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             cout,
    output logic             c_msb,
    output logic             p_grp,
    output logic             g_grp
);

    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, expanded rather than rippled.
    always_comb begin
        logic acc;
        logic prod;
        acc  = 1'b0;
        prod = 1'b0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < GROUP; i++) begin
            acc  = g[i];
            prod = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (g[j] & prod);
                prod = prod & p[j];
            end
            c[i+1] = acc | (cin & prod);
        end
    end

    always_comb begin
        g_grp = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            g_grp = g[i] | (p[i] & g_grp);
        end
    end

    assign sum   = p ^ c[GROUP-1:0];
    assign cout  = c[GROUP];
    assign c_msb = c[GROUP-1];
    assign p_grp = &p;

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit slice per stage, with
// the carry and the not-yet-consumed operand bits skewed down the pipe.
module cla_adder_pipe
    import cla_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GROUP = DEF_GROUP
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NSTAGE = nstage(WIDTH, GROUP);

    if (!params_ok(WIDTH, GROUP)) begin : g_bad_params
        $fatal(1, "cla_adder_pipe: WIDTH (%0d) must be a positive multiple of GROUP (%0d)", WIDTH, GROUP);
    end

    // Handshake: in-transfer = in_valid & in_ready, out-transfer = out_valid & out_ready.
    // All stages move together when the output slot is empty or is being drained.
    logic advance;
    logic last_vld;
    assign advance  = !last_vld | out_ready;
    assign in_ready = advance;

    // Operand capture; subtraction is folded in here as a + ~b + 1.
    logic [WIDTH-1:0] a0_q;
    logic [WIDTH-1:0] b0_q;
    logic             c0_q;
    logic             v0_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            a0_q <= '0;
            b0_q <= '0;
            c0_q <= 1'b0;
            v0_q <= 1'b0;
        end else if (advance) begin
            a0_q <= a;
            b0_q <= sub ? ~b : b;
            c0_q <= sub | c_in;
            v0_q <= in_valid;
        end
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stg
        localparam int LO = k * GROUP;
        localparam int HI = LO + GROUP;

        logic [WIDTH-LO-1:0] a_in;
        logic [WIDTH-LO-1:0] b_in;
        logic                c_in_s;
        logic                v_in;
        logic [GROUP-1:0]    grp_sum;
        logic                grp_cout;
        logic                grp_cmsb;
        logic                grp_p;
        logic                grp_g;
        logic                pg_unused;
        logic [HI-1:0]       sum_d;
        logic [HI-1:0]       sum_q;
        logic                cy_q;
        logic                vld_q;

        if (k == 0) begin : g_src
            assign a_in   = a0_q;
            assign b_in   = b0_q;
            assign c_in_s = c0_q;
            assign v_in   = v0_q;
            assign sum_d  = grp_sum;
        end else begin : g_src
            assign a_in   = g_stg[k-1].g_fwd.a_q;
            assign b_in   = g_stg[k-1].g_fwd.b_q;
            assign c_in_s = g_stg[k-1].cy_q;
            assign v_in   = g_stg[k-1].vld_q;
            assign sum_d  = {grp_sum, g_stg[k-1].sum_q};
        end

        cla_group #(.GROUP(GROUP)) u_grp (
            .a     (a_in[GROUP-1:0]),
            .b     (b_in[GROUP-1:0]),
            .cin   (c_in_s),
            .sum   (grp_sum),
            .cout  (grp_cout),
            .c_msb (grp_cmsb),
            .p_grp (grp_p),
            .g_grp (grp_g)
        );
        assign pg_unused = grp_p ^ grp_g;

        always_ff @(posedge clock) begin
            if (reset) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                sum_q <= '0;
            end else if (advance) begin
                vld_q <= v_in;
                cy_q  <= grp_cout;
                sum_q <= sum_d;
            end
        end

        if (HI < WIDTH) begin : g_fwd
            logic [WIDTH-HI-1:0] a_q;
            logic [WIDTH-HI-1:0] b_q;
            logic                cmsb_unused;
            assign cmsb_unused = grp_cmsb;

            always_ff @(posedge clock) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_in[WIDTH-LO-1:GROUP];
                    b_q <= b_in[WIDTH-LO-1:GROUP];
                end
            end
        end else begin : g_tail
            // Signed overflow: carry into the MSB disagrees with carry out of it.
            logic ovf_q;
            always_ff @(posedge clock) begin
                if (reset) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= grp_cmsb ^ grp_cout;
                end
            end
        end
    end

    assign last_vld  = g_stg[NSTAGE-1].vld_q;
    assign out_valid = last_vld;
    assign sum       = g_stg[NSTAGE-1].sum_q;
    assign c_out     = g_stg[NSTAGE-1].cy_q;
    assign ovf       = g_stg[NSTAGE-1].g_tail.ovf_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed bench for cla_adder_pipe (WIDTH=16, GROUP=4, latency 4): reset state,
// single operations, wrap/overflow corners, a stalled stream and mid-flight reset.
module tb_cla_adder_pipe;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        c_out;
    logic        ovf;

    int n_vec  = 0;
    int n_miss = 0;

    logic [17:0] exp_q[$];

    cla_adder_pipe dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One isolated operation: accepted on the next edge, visible exactly 4 edges later for one cycle.
    task automatic run_one(input string tag, input logic [15:0] va, input logic [15:0] vb,
                           input logic vc, input logic vs,
                           input logic [15:0] e_sum, input logic e_c, input logic e_ovf);
        a = va; b = vb; c_in = vc; sub = vs; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk({tag, "_early"}, out_valid, 0);
        end
        tick();
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_sum"}, sum, e_sum);
        chk({tag, "_c_out"}, c_out, e_c);
        chk({tag, "_ovf"}, ovf, e_ovf);
        tick();
        chk({tag, "_one_cycle"}, out_valid, 0);
    endtask

    logic [15:0] ta [8] = '{16'h0001, 16'h1234, 16'h8000, 16'hFFFF, 16'h4000, 16'h00FF, 16'h0010, 16'h0000};
    logic [15:0] tb [8] = '{16'h0001, 16'h4321, 16'h8000, 16'hFFFF, 16'h4000, 16'h0F01, 16'h0010, 16'h0001};
    logic        ts [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    // {ovf, c_out, sum}
    logic [17:0] te [8] = '{18'h00002, 18'h05555, 18'h30000, 18'h1FFFE,
                            18'h28000, 18'h01000, 18'h10000, 18'h0FFFF};

    initial begin
        int idx;
        int got;
        int stall;
        int cyc;
        bit seen;
        logic [17:0] held;
        logic [17:0] exp;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_c_out", c_out, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_out_valid", out_valid, 0);
        end

        run_one("add_3_4",     16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
        run_one("add_wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_one("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_one("add_cin",     16'h1234, 16'h0FF0, 1'b1, 1'b0, 16'h2225, 1'b0, 1'b0);
        run_one("sub_borrow",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_one("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Back-to-back stream with a 3-cycle output stall once the first result shows.
        idx = 0; got = 0; stall = 0; cyc = 0; seen = 1'b0; held = '0;
        c_in = 1'b0;
        while (got < 8 && cyc < 200) begin
            if (out_valid && !seen) begin
                seen  = 1'b1;
                stall = 3;
                held  = {ovf, c_out, sum};
            end
            out_ready = (stall == 0);
            in_valid  = (idx < 8);
            if (idx < 8) begin
                a = ta[idx]; b = tb[idx]; sub = ts[idx];
            end
            #1;
            if (stall > 0) begin
                chk("stall_in_ready", in_ready, 0);
                chk("stall_out_valid", out_valid, 1);
                chk("stall_held", {ovf, c_out, sum}, held);
                stall--;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(te[idx]);
                idx++;
            end
            if (out_valid && out_ready) begin
                chk("stream_has_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp = exp_q.pop_front();
                    chk("stream_result", {ovf, c_out, sum}, exp);
                end
                got++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_count", got, 8);
        chk("stream_queue_empty", exp_q.size(), 0);
        tick();
        chk("stream_drained", out_valid, 0);

        // Reset with two operations in flight; reset also wins over in_valid.
        a = 16'h0101; b = 16'h0202; sub = 1'b0; in_valid = 1'b1;
        tick();
        a = 16'h0303; b = 16'h0404;
        tick();
        in_valid = 1'b0;
        tick();
        chk("pre_reset_out_valid", out_valid, 0);
        reset = 1'b1; in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
        tick();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_c_out", c_out, 0);
        tick();
        reset = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("post_reset_silent", out_valid, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
